hqm_list_sel_rf_pg_ctl: RTL and testbench
=========================================

HQM_LIST_SEL_RF_PG_CTL -- requirements
Module: hqm_list_sel_rf_pg_ctl

Interface
REQ-001 Parameter IDLE_W, default 8: width of the idle counter and of cfg_idle_limit.
REQ-002 clk  in  1  single functional clock; all state is on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cfg_idle_limit  in  IDLE_W  idle cycles in ON before auto power-down; 0 disables auto power-down.
REQ-005 force_on  in  1  1 = power up and remain powered.
REQ-006 wr0_req / wr1_req  in  1 each  write requests.
REQ-007 wr0_addr / wr1_addr  in  2 each  write addresses.
REQ-008 wr0_data / wr1_data  in  25 each  write data.
REQ-009 wr0_gnt / wr1_gnt  out  1 each  write accepted this cycle.
REQ-010 rd_req  in  1  read request.
REQ-011 rd_addr  in  2  read address.
REQ-012 rd_gnt  out  1  read accepted this cycle.
REQ-013 rd_v  out  1  read data valid.
REQ-014 rd_data  out  25  read data.
REQ-015 mem_we, mem_waddr[1:0], mem_wdata[24:0]  out  RF write port.
REQ-016 mem_re, mem_raddr[1:0]  out  RF read port.
REQ-017 mem_rdata  in  25  RF read data, valid the cycle after mem_re.
REQ-018 pgcb_isol_en  out  1  RF isolation control.
REQ-019 pwr_enable_b_in  out  1  RF power enable, active-low.
REQ-020 pwr_enable_b_out  in  1  RF power acknowledge, active-low.
REQ-021 pg_state  out  3  current FSM state encoding.

Function
REQ-022 FSM states and encodings SHALL be OFF=0, PUP=1, UNISO=2, ON=3, ISO=4, PDN=5.
REQ-023 OFF SHALL drive pwr_enable_b_in=1 and pgcb_isol_en=1, and SHALL go to PUP when any of wr0_req, wr1_req, rd_req or force_on is 1.
REQ-024 PUP SHALL drive pwr_enable_b_in=0 and isol=1, and SHALL go to UNISO the cycle after pwr_enable_b_out is sampled 0; PUP has no timeout.
REQ-025 UNISO SHALL last exactly 1 cycle with pwr=0 and isol=1, then go to ON.
REQ-026 ON SHALL drive pwr=0 and isol=0; grants are asserted only in ON.
REQ-027 Idle counter, reset to 0 on each entry to ON:
  - clears to 0 on any cycle with a request or rd_v asserted;
  - otherwise increments and saturates at all-ones.
REQ-028 ON SHALL go to ISO when all of the following hold: counter == cfg_idle_limit, cfg_idle_limit != 0, force_on=0, no request this cycle.
REQ-029 ISO SHALL last 1 cycle with isol=1 and pwr=0, then go to PDN.
REQ-030 PDN SHALL drive pwr=1 and isol=1, and SHALL go to OFF when pwr_enable_b_out is sampled 1.
REQ-031 A request arriving during ISO or PDN SHALL NOT abort power-down; the FSM completes to OFF, then re-enters PUP the next cycle.
REQ-032 Write arbitration (combinational grant in ON):
  - round-robin between wr0 and wr1;
  - priority pointer resets to wr0 and moves to the other requester after each write grant;
  - a lone requester is granted every cycle.
REQ-033 mem_we SHALL equal wr0_gnt | wr1_gnt.
REQ-034 mem_waddr and mem_wdata SHALL come from the granted requester, and SHALL be 0 when there is no grant.
REQ-035 rd_gnt SHALL equal rd_req in ON; mem_re=rd_gnt and mem_raddr=rd_addr.
REQ-036 One write grant and one read grant MAY occur in the same cycle.
REQ-037 rd_v SHALL be rd_gnt delayed by exactly 1 cycle; rd_data SHALL be mem_rdata when rd_v=1, else 0.
REQ-038 A same-cycle read and write to the same address SHALL return the pre-write data; the block performs no forwarding.
REQ-039 Requesters SHALL hold req, addr and data stable until granted; the block has no input buffering.

Reset
REQ-040 On rst_n=0 the block SHALL immediately enter OFF with pgcb_isol_en=1, pwr_enable_b_in=1, all grants/mem_we/mem_re/rd_v=0, data outputs 0, pg_state=0, idle counter 0, RR pointer=wr0.
REQ-041 Reset asserted mid-read SHALL drop rd_v with no later delivery; reset mid-PUP or mid-PDN SHALL force OFF regardless of pwr_enable_b_out.

Verification
REQ-042 Cold start: after reset, wr0_req=1 with addr 2, data 0x1ABCDEF; RF ack returns 2 cycles after pwr=0 -> FSM OFF->PUP->UNISO->ON; wr0_gnt=1 on the first ON cycle with mem_waddr=2, mem_wdata=0x1ABCDEF.
REQ-043 Round-robin: in ON, wr0_req=wr1_req=1 held for 4 cycles -> grants alternate wr0, wr1, wr0, wr1.
REQ-044 Read latency: rd_req at addr 2 after REQ-042 -> rd_gnt same cycle; next cycle rd_v=1, rd_data=0x1ABCDEF.
REQ-045 Idle power-down: cfg_idle_limit=5, no requests -> ISO after 5 idle cycles (on the 6th cycle in ON), then PDN; pwr_enable_b_out=1 -> OFF with isol=1.
REQ-046 Request during PDN: rd_req=1 asserted in PDN -> FSM completes to OFF, then PUP, UNISO, ON; rd_gnt only in ON.
REQ-047 Hold-on: force_on=1, cfg_idle_limit=1, 100 idle cycles -> FSM stays ON; asserting rst_n=0 mid-ON -> OFF outputs per REQ-040 in the same cycle.

Source files
------------

// File: rtl/hqm_list_sel_rf_pg_ctl.sv
// Power-gating controller for a 4-entry x 25-bit register file with two
// round-robin write ports and one read port, gated by an idle counter.
module hqm_list_sel_rf_pg_ctl #(
  parameter int IDLE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDLE_W-1:0] cfg_idle_limit,
  input  logic              force_on,
  input  logic              wr0_req,
  input  logic [1:0]        wr0_addr,
  input  logic [24:0]       wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [1:0]        wr1_addr,
  input  logic [24:0]       wr1_data,
  output logic              wr1_gnt,
  input  logic              rd_req,
  input  logic [1:0]        rd_addr,
  output logic              rd_gnt,
  output logic              rd_v,
  output logic [24:0]       rd_data,
  output logic              mem_we,
  output logic [1:0]        mem_waddr,
  output logic [24:0]       mem_wdata,
  output logic              mem_re,
  output logic [1:0]        mem_raddr,
  input  logic [24:0]       mem_rdata,
  output logic              pgcb_isol_en,
  output logic              pwr_enable_b_in,
  input  logic              pwr_enable_b_out,
  output logic [2:0]        pg_state
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PUP   = 3'd1,
    UNISO = 3'd2,
    ON    = 3'd3,
    ISO   = 3'd4,
    PDN   = 3'd5
  } pg_state_t;

  pg_state_t         state;
  pg_state_t         state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              rr_ptr;
  logic              rd_v_q;
  logic              pwr_b_q;
  logic              isol_q;
  logic              any_req;
  logic              is_on;

  assign any_req = wr0_req | wr1_req | rd_req;
  assign is_on   = (state == ON);

  // Handshake: a requester raises req with stable addr/data and holds all
  // three until the matching gnt is seen high; the transfer happens in that
  // same cycle. Grants only ever assert in ON.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (any_req || force_on) state_nxt = PUP;
      PUP:     if (!pwr_enable_b_out) state_nxt = UNISO;
      UNISO:   state_nxt = ON;
      ON:      if ((idle_cnt == cfg_idle_limit) && (cfg_idle_limit != '0) &&
                   !force_on && !any_req) state_nxt = ISO;
      ISO:     state_nxt = PDN;
      PDN:     if (pwr_enable_b_out) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  // rr_ptr = 0 gives wr0 priority on a tie; a lone requester always wins.
  assign wr0_gnt = is_on && wr0_req && (!wr1_req || !rr_ptr);
  assign wr1_gnt = is_on && wr1_req && (!wr0_req || rr_ptr);
  assign rd_gnt  = is_on && rd_req;

  assign mem_we    = wr0_gnt | wr1_gnt;
  assign mem_waddr = wr0_gnt ? wr0_addr : (wr1_gnt ? wr1_addr : 2'd0);
  assign mem_wdata = wr0_gnt ? wr0_data : (wr1_gnt ? wr1_data : 25'd0);
  assign mem_re    = rd_gnt;
  assign mem_raddr = rd_addr;

  assign rd_v            = rd_v_q;
  assign rd_data         = rd_v_q ? mem_rdata : 25'd0;
  assign pgcb_isol_en    = isol_q;
  assign pwr_enable_b_in = pwr_b_q;
  assign pg_state        = state;

  // Power/isolation controls are registered from the next state so they
  // change together with pg_state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      pwr_b_q  <= 1'b1;
      isol_q   <= 1'b1;
      idle_cnt <= '0;
      rr_ptr   <= 1'b0;
      rd_v_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwr_b_q <= (state_nxt == OFF) || (state_nxt == PDN);
      isol_q  <= (state_nxt != ON);
      rd_v_q  <= rd_gnt;
      if (is_on && (state_nxt == ON)) begin
        if (any_req || rd_v_q)   idle_cnt <= '0;
        else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
      if (wr0_gnt)      rr_ptr <= 1'b1;
      else if (wr1_gnt) rr_ptr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hqm_list_sel_rf_pg_ctl.sv
// Bench for hqm_list_sel_rf_pg_ctl: directed power-state scenarios followed by
// random traffic, every cycle compared with a behavioural model.
module tb_hqm_list_sel_rf_pg_ctl;

  localparam int IDLE_W = 8;
  localparam int CNT_MAX = (1 << IDLE_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IDLE_W-1:0] cfg_idle_limit;
  logic              force_on;
  logic              wr0_req, wr1_req, rd_req;
  logic [1:0]        wr0_addr, wr1_addr, rd_addr;
  logic [24:0]       wr0_data, wr1_data;
  logic              wr0_gnt, wr1_gnt, rd_gnt, rd_v;
  logic [24:0]       rd_data;
  logic              mem_we, mem_re;
  logic [1:0]        mem_waddr, mem_raddr;
  logic [24:0]       mem_wdata, mem_rdata;
  logic              pgcb_isol_en, pwr_enable_b_in, pwr_enable_b_out;
  logic [2:0]        pg_state;

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  hqm_list_sel_rf_pg_ctl #(.IDLE_W(IDLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_idle_limit(cfg_idle_limit), .force_on(force_on),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_v(rd_v), .rd_data(rd_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .pgcb_isol_en(pgcb_isol_en), .pwr_enable_b_in(pwr_enable_b_in),
    .pwr_enable_b_out(pwr_enable_b_out), .pg_state(pg_state)
  );

  // Register file: read data appears the cycle after mem_re, pre-write value.
  logic [24:0] rf [4];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rf[mem_raddr];
    if (mem_we) rf[mem_waddr] <= mem_wdata;
  end

  // Power switch acknowledge follows the enable two cycles later.
  logic [1:0] ack_sh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sh <= 2'b11;
    else        ack_sh <= {ack_sh[0], pwr_enable_b_in};
  end
  assign pwr_enable_b_out = ack_sh[1];

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States named by number: 0 off, 1 power-up, 2 un-isolate, 3 on, 4 isolate, 5 power-down.
  int          m_state, m_idle, n_state, n_idle;
  bit          m_prio1, m_rdv, n_prio1, n_rdv;
  logic [24:0] m_rdq, n_rdq;
  logic [24:0] m_mem [4];
  logic [24:0] exp_q [$];     // data expected on rd_data, one entry per read grant
  bit          e_g0, e_g1, e_rg;

  task automatic model_reset();
    m_state = 0; m_idle = 0; m_prio1 = 0; m_rdv = 0; m_rdq = '0;
    exp_q.delete();
  endtask

  // Compare DUT outputs for the current cycle and prepare the model's next state.
  task automatic sample();
    bit on, anyr;
    logic [1:0]  e_wa;
    logic [24:0] e_wd, e_rd;
    @(negedge clk);
    on   = (m_state == 3);
    anyr = wr0_req || wr1_req || rd_req;
    e_g0 = 0; e_g1 = 0;
    if (on) begin
      if (wr0_req && wr1_req) begin
        if (m_prio1) e_g1 = 1; else e_g0 = 1;
      end else begin
        e_g0 = wr0_req; e_g1 = wr1_req;
      end
    end
    e_rg = on && rd_req;
    e_wa = e_g0 ? wr0_addr : (e_g1 ? wr1_addr : 2'd0);
    e_wd = e_g0 ? wr0_data : (e_g1 ? wr1_data : 25'd0);
    e_rd = m_rdv ? m_rdq : 25'd0;
    chk("pg_state",  32'(pg_state),        32'(m_state));
    chk("pwr_b",     32'(pwr_enable_b_in), 32'(m_state == 0 || m_state == 5));
    chk("isol",      32'(pgcb_isol_en),    32'(m_state != 3));
    chk("wr0_gnt",   32'(wr0_gnt),         32'(e_g0));
    chk("wr1_gnt",   32'(wr1_gnt),         32'(e_g1));
    chk("rd_gnt",    32'(rd_gnt),          32'(e_rg));
    chk("mem_we",    32'(mem_we),          32'(e_g0 || e_g1));
    chk("mem_waddr", 32'(mem_waddr),       32'(e_wa));
    chk("mem_wdata", 32'(mem_wdata),       32'(e_wd));
    chk("mem_re",    32'(mem_re),          32'(e_rg));
    chk("mem_raddr", 32'(mem_raddr),       32'(rd_addr));
    chk("rd_v",      32'(rd_v),            32'(m_rdv));
    chk("rd_data",   32'(rd_data),         32'(e_rd));
    n_state = m_state;
    case (m_state)
      0: if (anyr || force_on) n_state = 1;
      1: if (pwr_enable_b_out == 1'b0) n_state = 2;
      2: n_state = 3;
      3: if (m_idle == int'(cfg_idle_limit) && cfg_idle_limit != 0 && !force_on && !anyr)
           n_state = 4;
      4: n_state = 5;
      5: if (pwr_enable_b_out == 1'b1) n_state = 0;
      default: n_state = 0;
    endcase
    if (on && n_state == 3) n_idle = (anyr || m_rdv) ? 0 : ((m_idle < CNT_MAX) ? m_idle + 1 : m_idle);
    else                    n_idle = 0;
    n_prio1 = e_g0 ? 1'b1 : (e_g1 ? 1'b0 : m_prio1);
    n_rdv   = e_rg;
    n_rdq   = e_rg ? m_mem[rd_addr] : m_rdq;
    if (e_rg) exp_q.push_back(m_mem[rd_addr]);
    if (m_rdv && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_g0) m_mem[wr0_addr] = wr0_data;
    if (e_g1) m_mem[wr1_addr] = wr1_data;
    m_state = n_state; m_idle = n_idle; m_prio1 = n_prio1; m_rdv = n_rdv; m_rdq = n_rdq;
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_state", 32'(pg_state),        32'd0);
    chk("rst_pwr_b", 32'(pwr_enable_b_in), 32'd1);
    chk("rst_isol",  32'(pgcb_isol_en),    32'd1);
    chk("rst_gnts",  32'({wr0_gnt, wr1_gnt, rd_gnt}), 32'd0);
    chk("rst_mem",   32'({mem_we, mem_re}), 32'd0);
    chk("rst_wdat",  32'({mem_waddr, mem_wdata}), 32'd0);
    chk("rst_rdv",   32'(rd_v),    32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random driver: a requester holds req/addr/data until its grant is seen.
  task automatic drive_random(input int pct);
    if (!wr0_req || e_g0) begin
      wr0_req = ($urandom_range(99) < pct); wr0_addr = 2'($urandom_range(3)); wr0_data = 25'($urandom);
    end
    if (!wr1_req || e_g1) begin
      wr1_req = ($urandom_range(99) < pct); wr1_addr = 2'($urandom_range(3)); wr1_data = 25'($urandom);
    end
    if (!rd_req || e_rg) begin
      rd_req = ($urandom_range(99) < pct); rd_addr = 2'($urandom_range(3));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit seen;
    int n_on;
    int seq [$];
    for (int i = 0; i < 4; i++) begin rf[i] = '0; m_mem[i] = '0; end
    mem_rdata = '0;
    cfg_idle_limit = '0; force_on = 0;
    wr0_req = 0; wr1_req = 0; rd_req = 0;
    wr0_addr = 0; wr1_addr = 0; rd_addr = 0; wr0_data = 0; wr1_data = 0;
    e_g0 = 0; e_g1 = 0; e_rg = 0;
    rst_n = 1'b1;
    #1;
    do_reset();
    cycle();

    // Cold start with a single write to address 2.
    wr0_req = 1; wr0_addr = 2; wr0_data = 25'h1ABCDEF;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      sample();
      if (m_state == 3) begin
        chk("cold_wr0_gnt", 32'(wr0_gnt),   32'd1);
        chk("cold_waddr",   32'(mem_waddr), 32'd2);
        chk("cold_wdata",   32'(mem_wdata), 32'h1ABCDEF);
        seen = 1;
      end
      advance();
    end
    chk("cold_reach_on", 32'(seen), 32'd1);
    wr0_req = 0;

    // Read back after the write: grant same cycle, data one cycle later.
    rd_req = 1; rd_addr = 2;
    sample(); chk("rd_gnt_now", 32'(rd_gnt), 32'd1); advance();
    rd_req = 0;
    sample(); chk("rd_v_next", 32'(rd_v), 32'd1); chk("rd_data_next", 32'(rd_data), 32'h1ABCDEF); advance();

    // Lone wr1 write moves priority back to wr0, then a held tie alternates.
    wr1_req = 1; wr1_addr = 1; wr1_data = 25'h0000111;
    cycle();
    wr0_req = 1; wr0_addr = 0; wr0_data = 25'h0AAAAAA;
    wr1_addr = 3; wr1_data = 25'h1555555;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rr_wr0", 32'(wr0_gnt), 32'((i % 2) == 0));
      chk("rr_wr1", 32'(wr1_gnt), 32'((i % 2) == 1));
      advance();
    end
    wr0_req = 0; wr1_req = 0;

    // Idle power-down with limit 5: six idle ON cycles, then isolate.
    cfg_idle_limit = 5;
    n_on = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      if (pg_state == 3'd3) n_on++; else seen = 1;
      advance();
    end
    chk("idle_on_cycles", 32'(n_on), 32'd6);
    sample(); chk("idle_then_pdn", 32'(pg_state), 32'd5); advance();

    // Read request during power-down: completes to OFF, then powers back up.
    rd_req = 1; rd_addr = 2;
    seq.delete();
    seq.push_back(5);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      sample();
      if (int'(pg_state) != seq[$]) seq.push_back(int'(pg_state));
      if (pg_state == 3'd0) chk("off_isol", 32'(pgcb_isol_en), 32'd1);
      if (pg_state == 3'd3) begin
        chk("pdn_rd_gnt_on", 32'(rd_gnt), 32'd1);
        seen = 1;
      end
      advance();
    end
    chk("pdn_seq_len", 32'(seq.size()), 32'd5);
    if (seq.size() == 5)
      chk("pdn_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0]}, 32'h50123);
    rd_req = 0;
    cycle();

    // Hold-on: forced power stays ON despite a tiny idle limit.
    force_on = 1; cfg_idle_limit = 1;
    n_on = 0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (pg_state == 3'd3) n_on++;
      advance();
    end
    chk("force_stays_on", 32'(n_on), 32'd100);
    do_reset();
    force_on = 0;

    // Random traffic in segments of varying activity, limits and resets.
    for (int seg = 0; seg < 70; seg++) begin
      int pct;
      case ($urandom_range(3))
        0: pct = 0;
        1: pct = 5;
        2: pct = 30;
        default: pct = 70;
      endcase
      cfg_idle_limit = IDLE_W'($urandom_range(8));
      force_on = ($urandom_range(99) < 15);
      if ($urandom_range(7) == 0) do_reset();
      for (int c = 0; c < 40; c++) begin
        cycle();
        drive_random(pct);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
